// File: rtl/sar_search_32bit.sv
// Successive-approximation search controller: recovers an unknown operand A by
// driving trial values into an external comparator, one comparison per cycle.
module sar_search_32bit #(
    parameter int WIDTH = 32,
    parameter int STEPW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             early,
    output logic             err,
    output logic [STEPW-1:0] steps
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [STEPW-1:0] steps_q, steps_d;
    logic             early_q, early_d;
    logic             err_q, err_d;

    logic             onehot;
    logic [WIDTH-1:0] acc_new;

    assign onehot  = ( cmp_greater & ~cmp_equal & ~cmp_less) |
                     (~cmp_greater &  cmp_equal & ~cmp_less) |
                     (~cmp_greater & ~cmp_equal &  cmp_less);
    // A > trial keeps the trial bit; A < trial drops it.
    assign acc_new = cmp_greater ? trial_q : acc_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mask_d   = mask_q;
        trial_d  = trial_q;
        result_d = result_q;
        steps_d  = steps_q;
        early_d  = early_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mask_d   = MSB;
                    trial_d  = MSB;
                    steps_d  = '0;
                    result_d = '0;
                    early_d  = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                steps_d = steps_q + STEPW'(1);
                if (!onehot) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    result_d = acc_q;
                end else if (cmp_equal) begin
                    state_d  = DONE;
                    early_d  = 1'b1;
                    result_d = trial_q;
                end else if (mask_q[0]) begin
                    state_d  = DONE;
                    result_d = acc_new;
                end else begin
                    mask_d  = mask_q >> 1;
                    acc_d   = acc_new;
                    trial_d = acc_new | (mask_q >> 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mask_q   <= '0;
            trial_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            early_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mask_q   <= mask_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            early_q  <= early_d;
            err_q    <= err_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign early  = early_q;
    assign err    = err_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_32bit.sv
// Directed + randomized bench for sar_search_32bit; the comparator and the
// expected search outcome are modelled arithmetically from the operand A.
module tb_sar_search_32bit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cmp_greater, cmp_equal, cmp_less;
    logic [W-1:0]  trial, result;
    logic          busy, done, early, err;
    logic [5:0]    steps;

    logic [W-1:0]  a_op = '0;
    int            comp_no = 0;
    int            fault_step = 0;  // comparison number to corrupt, 0 = none
    int            fault_kind = 0;  // 0: greater+less both set, 1: no flag set
    int            checks = 0;
    int            errors = 0;

    sar_search_32bit #(.WIDTH(W), .STEPW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
        .trial(trial), .busy(busy), .done(done), .result(result),
        .early(early), .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    always_comb begin
        cmp_greater = a_op > trial;
        cmp_equal   = a_op == trial;
        cmp_less    = a_op < trial;
        if (busy && fault_step != 0 && comp_no == fault_step) begin
            cmp_greater = (fault_kind == 0);
            cmp_equal   = 1'b0;
            cmp_less    = (fault_kind == 0);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trial at comparison k: bits of A above the probe position, plus the probe bit.
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] a, input int k);
        logic [63:0] hi;
        hi = 64'd1 << (W - k + 1);
        return W'((64'(a) & ~(hi - 64'd1)) | (64'd1 << (W - k)));
    endfunction

    function automatic int model_steps(input logic [W-1:0] a);
        if (a == '0) return W;
        for (int i = 0; i < W; i++) if (a[i]) return W - i;
        return W;
    endfunction

    // Runs one search. pulse_mask bit n pulses start during comparison n.
    task automatic search(input string tag, input logic [W-1:0] a, input logic exp_err,
                          input logic [W-1:0] exp_res, input int exp_steps,
                          input logic exp_early, input logic [31:0] pulse_mask);
        int edges, busy_cnt;
        bit got;
        a_op    = a;
        comp_no = 1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk({tag, " busy@start"}, W'(busy), W'(1));
        chk({tag, " first trial"}, trial, {1'b1, {(W-1){1'b0}}});
        edges = 1; busy_cnt = 0; got = 0;
        while (edges <= W + 2) begin
            if (busy) busy_cnt++;
            if (comp_no <= exp_steps) chk($sformatf("%s trial%0d", tag, comp_no), trial, model_trial(a, comp_no));
            if (comp_no < 32 && pulse_mask[comp_no]) start = 1'b1;
            tick();
            start = 1'b0;
            edges++;
            comp_no++;
            if (done) begin got = 1; break; end
        end
        chk({tag, " done seen"}, W'(got), W'(1));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " steps"}, W'(steps), W'(exp_steps));
        chk({tag, " early"}, W'(early), W'(exp_early));
        chk({tag, " err"}, W'(err), W'(exp_err));
        chk({tag, " busy low"}, W'(busy), W'(0));
        chk({tag, " latency"}, W'(edges), W'(exp_steps + 1));
        chk({tag, " busy cycles"}, W'(busy_cnt), W'(exp_steps));
        fault_step = 0;
    endtask

    task automatic good(input string tag, input logic [W-1:0] a, input logic [31:0] pm);
        search(tag, a, 1'b0, a, model_steps(a), a != '0, pm);
    endtask

    initial begin
        logic [W-1:0] r;
        #2;
        chk("rst trial", trial, '0);
        chk("rst result", result, '0);
        chk("rst steps", W'(steps), '0);
        chk("rst flags", W'({busy, done, early, err}), '0);
        #10 rst_n = 1'b1;
        tick();

        good("msb", 32'h8000_0000, 0);
        tick();
        good("mixed", 32'h1234_5678, 0);
        tick();
        good("zero", 32'h0000_0000, 0);
        tick();
        good("ones", 32'hFFFF_FFFF, 0);
        tick();

        fault_step = 3; fault_kind = 0;
        search("fault2hot", 32'hF000_0000, 1'b1, 32'hC000_0000, 3, 1'b0, 0);
        tick();
        fault_step = 1; fault_kind = 1;
        search("fault0hot", 32'h0F00_0000, 1'b1, 32'h0000_0000, 1, 1'b0, 0);
        tick();

        good("ignstart", 32'h0000_0100, (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 20));
        // Immediately from DONE: start is held, so the next run begins without IDLE.
        chk("b2b in done", W'(done), W'(1));
        good("b2b", 32'h00AB_CDE0, 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            r = r & ~((32'd1 << $urandom_range(0, 20)) - 32'd1);
            good($sformatf("rand%0d", i), r, 0);
            if (i[0]) tick();
        end
        tick();

        // Asynchronous reset in the middle of comparison 10.
        a_op = 32'h0000_0003; comp_no = 1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i < 10; i++) begin tick(); comp_no++; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst trial", trial, '0);
        chk("arst result", result, '0);
        chk("arst steps", W'(steps), '0);
        chk("arst flags", W'({busy, done, early, err}), '0);
        tick();
        chk("arst no done", W'(done), '0);
        rst_n = 1'b1;
        tick();
        chk("post rst idle", W'({busy, done}), '0);
        good("one", 32'h0000_0001, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sar_search_32bit.md
# sar_search_32bit

Successive-approximation controller that recovers an unknown WIDTH-bit unsigned operand A by binary search against an external magnitude comparator. It drives the comparator's B operand (`trial`) one trial per cycle and consumes the comparator's greater/equal/less flags. It sits on the initiator side of the 32-bit comparator interface and is used for threshold search and self-test of comparator instances.

## Interface
Parameters:
- WIDTH, 32, operand width; legal range 2..32.
- STEPW, 6, width of `steps`; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new search; sampled in IDLE or DONE only.
- cmp_greater  in  1  comparator flag: A > trial.
- cmp_equal  in  1  comparator flag: A == trial.
- cmp_less  in  1  comparator flag: A < trial.
- trial  out  WIDTH  registered operand driven to the comparator's B input.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a search completes.
- result  out  WIDTH  recovered value; held from `done` until the next accepted start.
- early  out  1  search ended on a `cmp_equal` hit; valid with `done`, held.
- err  out  1  flags were not one-hot; the search was aborted. Valid with `done`, held.
- steps  out  STEPW  number of comparisons consumed; valid with `done`, held.

## Operation
- Internal state: accumulator `acc` (WIDTH), one-hot `mask` (WIDTH), step counter.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 -> RUN:
  - acc=0, mask=1<<(WIDTH-1), trial=1<<(WIDTH-1), steps=0.
  - err, early and result clear to 0.
- RUN, each cycle: sample the flags for the current `trial`, then increment steps.
  - Flags not exactly one-hot (none set, or more than one set) -> DONE with err=1, result=acc.
  - cmp_equal -> DONE with early=1, result=trial.
  - cmp_greater -> acc_new = trial. cmp_less -> acc_new = acc.
  - If mask is bit 0 and there was no equal hit -> DONE with result=acc_new, early=0.
  - Otherwise: mask >>= 1, acc=acc_new, trial=acc_new|(mask>>1).
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 here re-enters RUN directly, so back-to-back searches are allowed.
  - Otherwise go to IDLE.
- start is ignored while in RUN.
- `trial` holds its last value in IDLE and DONE.
- Arithmetic is unsigned. No carries: trial is always acc OR one mask bit.
- Expected steps: for A≠0, steps = WIDTH - (index of the lowest set bit of A) and early=1. For A=0, steps=WIDTH, result=0, early=0.

## Timing
- Reset (rst_n=0) takes effect immediately, regardless of clk:
  - state=IDLE.
  - trial, result and steps are all zero.
  - busy, done, early and err are all 0.
- Reset mid-search abandons the search; no `done` is produced.
- start high at edge E0 -> RUN after E0; busy=1 and trial=first trial, both visible after E0.
- The comparator is combinational: flags are sampled at E1..Ek for k comparisons.
- After Ek: DONE, with done, result, early, err and steps all updated at the same edge.
- Latency from the start edge to done: k+1 edges. Maximum is WIDTH+1.
- busy falls at the same edge that done rises.
- A start at the DONE edge (Ek+1) begins the next RUN, with trial=MSB visible after Ek+1.

## Test plan
- A=0x8000_0000 (bench comparator models A vs trial), pulse start -> done after 2 edges, result=0x8000_0000, steps=1, early=1, err=0.
- A=0x1234_5678 -> result=0x1234_5678, steps=29, early=1; trial sequence starts 0x8000_0000, 0x4000_0000, 0x2000_0000, 0x1000_0000, 0x1800_0000.
- A=0x0000_0000 and A=0xFFFF_FFFF -> result=0, steps=32, early=0; then result=0xFFFF_FFFF, steps=32, early=1; busy high for exactly 32 cycles in each.
- Fault injection: force cmp_greater=cmp_less=1 on the 3rd comparison for A=0xF000_0000 -> done at step 3, err=1, result=0xC000_0000, steps=3. All-zero flags on the 1st comparison -> err=1, result=0, steps=1.
- Pulse start at cycles 1, 5 and 20 of a RUN -> ignored, with no trial perturbation. Start held high in DONE -> a second search begins with no IDLE cycle and produces a correct result.
- Assert rst_n low asynchronously at comparison 10 -> all outputs zero immediately with no done pulse. After release, a fresh start with A=0x0000_0001 -> result=1, steps=32, early=1.
